// File: rtl/fifo_addr_storage.sv
// fifo_addr_storage: circular FIFO storage array with wrapping write/read address generators
module fifo_addr_storage #(
  parameter int MAX_DATA = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wptr_en,
  input  logic              rptr_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_DATA - 1);
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0] mem_q [MAX_DATA];
  always_comb begin
    waddr_d = wptr_en ? (waddr_q == LAST ? '0 : waddr_q + 1'b1) : waddr_q;
    raddr_d = rptr_en ? (raddr_q == LAST ? '0 : raddr_q + 1'b1) : raddr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      waddr_q <= '0;
      raddr_q <= '0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
    end
  always_ff @(posedge clk)
    if (rst_n && wen) mem_q[waddr_q] <= wdata;
  assign waddr = waddr_q;
  assign raddr = raddr_q;
  assign rdata = mem_q[raddr_q];
endmodule

// File: tb/tb_fifo_addr_storage.sv
// tb_fifo_addr_storage: randomized and directed checks of fifo_addr_storage against a queue-free array model
module tb_fifo_addr_storage;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wen = 1'b0;
  logic wptr_en = 1'b0;
  logic rptr_en = 1'b0;
  logic [7:0] wdata = '0;
  logic [3:0] waddr, raddr;
  logic [7:0] rdata;
  int n_chk = 0;
  int n_err = 0;
  int wp = 0;
  int rp = 0;
  logic [7:0] m [N];
  bit v [N];
  fifo_addr_storage #(.MAX_DATA(N), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata),
    .wptr_en(wptr_en), .rptr_en(rptr_en),
    .waddr(waddr), .raddr(raddr), .rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_waddr"}, 8'(waddr), 8'(wp));
    chk({tag, "_raddr"}, 8'(raddr), 8'(rp));
    if (v[rp]) chk({tag, "_rdata"}, rdata, m[rp]);
  endtask
  task automatic step(input string tag, input bit w, input bit we, input bit re, input logic [7:0] d);
    wen = w;
    wptr_en = we;
    rptr_en = re;
    wdata = d;
    @(posedge clk);
    if (w) begin
      m[wp] = d;
      v[wp] = 1'b1;
    end
    if (we) wp = (wp + 1) % N;
    if (re) rp = (rp + 1) % N;
    @(negedge clk);
    chk_all(tag);
  endtask
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    wp = 0;
    rp = 0;
    chk({tag, "_async_waddr"}, 8'(waddr), 8'd0);
    chk({tag, "_async_raddr"}, 8'(raddr), 8'd0);
    wen = 1'b1;
    wptr_en = 1'b1;
    rptr_en = 1'b1;
    wdata = 8'hEE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all({tag, "_in_reset"});
    wen = 1'b0;
    wptr_en = 1'b0;
    rptr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_all({tag, "_released"});
  endtask
  initial begin
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    #2;
    chk("reset_waddr", 8'(waddr), 8'd0);
    chk("reset_raddr", 8'(raddr), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("pre_w", 1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) step("pre_r", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ptr5", 8'(waddr), 8'd5);
    chk("ptr3", 8'(raddr), 8'd3);
    pulse_reset("rst1");
    chk("rst1_mem0", rdata, 8'h40);
    for (int i = 0; i < N; i++) step("fill", 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
    chk("fill_wrap", 8'(waddr), 8'd0);
    for (int i = 0; i < N; i++) begin
      chk("drain_zero_lat", rdata, 8'(8'h10 + i));
      step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
    end
    chk("drain_wrap", 8'(raddr), 8'd0);
    step("adv", 1'b0, 1'b1, 1'b1, 8'h00);
    step("adv", 1'b0, 1'b1, 1'b1, 8'h00);
    step("same_slot", 1'b1, 1'b0, 1'b0, 8'hA5);
    chk("same_slot_vis", rdata, 8'hA5);
    step("simul", 1'b1, 1'b1, 1'b1, 8'hA5);
    chk("simul_w3", 8'(waddr), 8'd3);
    chk("simul_r3", 8'(raddr), 8'd3);
    pulse_reset("rst2");
    for (int i = 0; i < 15; i++) step("ow_fill", 1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    step("ow", 1'b1, 1'b1, 1'b1, 8'h3F);
    chk("ow_waddr", 8'(waddr), 8'd0);
    chk("ow_raddr", 8'(raddr), 8'd1);
    chk("ow_rdata", rdata, 8'h31);
    for (int i = 0; i < 10; i++) step("hold", 1'b0, 1'b0, 1'b0, 8'(i));
    step("ret_w", 1'b1, 1'b0, 1'b0, 8'h5A);
    pulse_reset("rst3");
    chk("retain", rdata, 8'h5A);
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
